ex_mem_reg: RTL and testbench



---
 rtl/ex_mem_reg_pkg.sv | 18 +
 rtl/ex_mem_reg_ctl_dff.sv | 35 +++
 rtl/ex_mem_reg.sv | 110 +++++++++++
 tb/tb_ex_mem_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_reg_pkg.sv
// Shared pipeline constants for the EX/MEM boundary of the MIPS32 core.
// Widths follow the core's RegBus/RegAddrBus/AluOpBus conventions.
package ex_mem_reg_pkg;

    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
    localparam logic [7:0]  EXE_NOP_OP    = 8'b0000_0000;
    localparam logic [7:0]  EXE_LW_OP     = 8'b1110_0011;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        STOP          = 1'b1;
    localparam logic        NO_STOP       = 1'b0;

    // Stall vector bit positions.
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

endpackage

// File: rtl/ex_mem_reg_ctl_dff.sv
// Width-parameterised pipeline register with rst/flush/bubble/hold controls.
// Bubble and advance each load a caller-chosen value so one cell serves both bundles.
module pipe_ctl_dff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         bubble,
    input  logic         hold,
    input  logic [W-1:0] adv_d_i,
    input  logic [W-1:0] bub_d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (rst || flush)
            q_d = '0;
        else if (bubble)
            q_d = bub_d_i;
        else if (!hold)
            q_d = adv_d_i;
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: registers EX results toward MEM, and recirculates
// the MADD/MSUB partial product and cycle count to EX while EX is stalled.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 8,
    parameter int STW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [STW-1:0]  stall,
    input  logic            flush,

    input  logic            ex_we,
    input  logic [AW-1:0]   ex_w_addr,
    input  logic [DW-1:0]   ex_w_data,
    input  logic [DW-1:0]   ex_hi,
    input  logic [DW-1:0]   ex_lo,
    input  logic            ex_hilo,
    input  logic [OPW-1:0]  ex_aluop,
    input  logic [DW-1:0]   ex_mem_addr,
    input  logic [DW-1:0]   ex_reg2,
    input  logic            ex_cp0_reg_we,
    input  logic [4:0]      ex_cp0_reg_write_addr,
    input  logic [DW-1:0]   ex_cp0_reg_data,
    input  logic [31:0]     ex_excepttype,
    input  logic            ex_is_in_delayslot,
    input  logic [DW-1:0]   ex_current_inst_address,
    input  logic [2*DW-1:0] hilo_i,
    input  logic [1:0]      cnt_i,

    output logic            mem_we,
    output logic [AW-1:0]   mem_w_addr,
    output logic [DW-1:0]   mem_w_data,
    output logic [DW-1:0]   mem_hi,
    output logic [DW-1:0]   mem_lo,
    output logic            mem_hilo,
    output logic [OPW-1:0]  mem_aluop,
    output logic [DW-1:0]   mem_mem_addr,
    output logic [DW-1:0]   mem_reg2,
    output logic            mem_cp0_reg_we,
    output logic [4:0]      mem_cp0_reg_write_addr,
    output logic [DW-1:0]   mem_cp0_reg_data,
    output logic [31:0]     mem_excepttype,
    output logic            mem_is_in_delayslot,
    output logic [DW-1:0]   mem_current_inst_address,
    output logic [2*DW-1:0] hilo_o,
    output logic [1:0]      cnt_o
);

    localparam int MW = 1 + AW + DW + DW + DW + 1 + OPW + DW + DW
                      + 1 + 5 + DW + 32 + 1 + DW;
    localparam int HW = 2 * DW + 2;

    logic bubble;
    logic hold;
    logic [MW-1:0] ex_bus;
    logic [MW-1:0] mem_bus;
    logic [HW-1:0] acc_bus;
    logic unused_stall;

    // stall[4] without stall[3] is not a legal ctrl output; it falls through to advance.
    assign bubble = stall[STALL_EX] & ~stall[STALL_MEM];
    assign hold   = stall[STALL_EX] &  stall[STALL_MEM];
    assign unused_stall = ^{stall[STW-1:STALL_MEM+1], stall[STALL_EX-1:0]};

    assign ex_bus = {ex_we, ex_w_addr, ex_w_data, ex_hi, ex_lo, ex_hilo, ex_aluop,
                     ex_mem_addr, ex_reg2, ex_cp0_reg_we, ex_cp0_reg_write_addr,
                     ex_cp0_reg_data, ex_excepttype, ex_is_in_delayslot,
                     ex_current_inst_address};

    // A bubble zeroes every field, so MEM sees a NOP with PC 0 and no write enables.
    pipe_ctl_dff #(.W(MW)) u_mem_bus (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .bubble  (bubble),
        .hold    (hold),
        .adv_d_i (ex_bus),
        .bub_d_i ({MW{1'b0}}),
        .q_o     (mem_bus)
    );

    // Accumulator state only lives across a bubble; advancing clears it.
    pipe_ctl_dff #(.W(HW)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .bubble  (bubble),
        .hold    (hold),
        .adv_d_i ({HW{1'b0}}),
        .bub_d_i ({hilo_i, cnt_i}),
        .q_o     (acc_bus)
    );

    assign {mem_we, mem_w_addr, mem_w_data, mem_hi, mem_lo, mem_hilo, mem_aluop,
            mem_mem_addr, mem_reg2, mem_cp0_reg_we, mem_cp0_reg_write_addr,
            mem_cp0_reg_data, mem_excepttype, mem_is_in_delayslot,
            mem_current_inst_address} = mem_bus;
    assign {hilo_o, cnt_o} = acc_bus;

`ifndef SYNTHESIS
    a_stall_combo: assert property (@(posedge clk) disable iff (rst || flush)
        !(stall[STALL_MEM] && !stall[STALL_EX]))
        else $error("ex_mem_reg: stall[4] set without stall[3]");
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: driver pushes model-predicted outputs,
// monitor pops one entry per clock and compares every output field.
module tb_ex_mem_reg;
    import ex_mem_reg_pkg::*;

    typedef struct {
        logic        we;
        logic [4:0]  w_addr;
        logic [31:0] w_data;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        hilo;
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] reg2;
        logic        cp0_we;
        logic [4:0]  cp0_addr;
        logic [31:0] cp0_data;
        logic [31:0] exc;
        logic        ds;
        logic [31:0] pc;
    } stage_t;

    typedef struct {
        stage_t      m;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    stage_t      ex;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;

    logic        mem_we, mem_hilo, mem_cp0_reg_we, mem_is_in_delayslot;
    logic [4:0]  mem_w_addr, mem_cp0_reg_write_addr;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_w_data, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [31:0] mem_cp0_reg_data, mem_excepttype, mem_current_inst_address;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_we(ex.we), .ex_w_addr(ex.w_addr), .ex_w_data(ex.w_data),
        .ex_hi(ex.hi), .ex_lo(ex.lo), .ex_hilo(ex.hilo), .ex_aluop(ex.aluop),
        .ex_mem_addr(ex.mem_addr), .ex_reg2(ex.reg2),
        .ex_cp0_reg_we(ex.cp0_we), .ex_cp0_reg_write_addr(ex.cp0_addr),
        .ex_cp0_reg_data(ex.cp0_data), .ex_excepttype(ex.exc),
        .ex_is_in_delayslot(ex.ds), .ex_current_inst_address(ex.pc),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_hilo(mem_hilo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_cp0_reg_we(mem_cp0_reg_we), .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr),
        .mem_cp0_reg_data(mem_cp0_reg_data), .mem_excepttype(mem_excepttype),
        .mem_is_in_delayslot(mem_is_in_delayslot),
        .mem_current_inst_address(mem_current_inst_address),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    exp_t exp_q[$];
    exp_t model;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    function automatic stage_t zero_stage();
        stage_t s;
        s = '{1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 8'd0, 32'd0, 32'd0,
              1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0};
        return s;
    endfunction

    function automatic stage_t ones_stage();
        stage_t s;
        s = '{1'b1, 5'h1F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 8'hFF,
              32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'h1F, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
        return s;
    endfunction

    function automatic stage_t rnd_stage();
        stage_t s;
        s.we = 1'($urandom);          s.w_addr = 5'($urandom);
        s.w_data = $urandom;          s.hi = $urandom;
        s.lo = $urandom;              s.hilo = 1'($urandom);
        s.aluop = 8'($urandom);       s.mem_addr = $urandom;
        s.reg2 = $urandom;            s.cp0_we = 1'($urandom);
        s.cp0_addr = 5'($urandom);    s.cp0_data = $urandom;
        s.exc = $urandom;             s.ds = 1'($urandom);
        s.pc = $urandom;
        return s;
    endfunction

    // Reference: what the EX/MEM boundary should show after one edge.
    function automatic exp_t predict(exp_t prev, bit r, bit f, logic [5:0] st,
                                     stage_t in, logic [63:0] hl, logic [1:0] c);
        exp_t n;
        if (r || f) begin
            n.m = zero_stage(); n.hilo = 64'd0; n.cnt = 2'd0;
        end else if (st[3] && st[4]) begin
            n = prev;
        end else if (st[3]) begin
            n.m = zero_stage(); n.hilo = hl; n.cnt = c;
        end else begin
            n.m = in; n.hilo = 64'd0; n.cnt = 2'd0;
        end
        return n;
    endfunction

    task automatic issue(bit r, bit f, logic [5:0] st, stage_t in,
                         logic [63:0] hl, logic [1:0] c);
        @(negedge clk);
        rst = r; flush = f; stall = st; ex = in; hilo_i = hl; cnt_i = c;
        model = predict(model, r, f, st, in, hl, c);
        exp_q.push_back(model);
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("mem_we",         64'(mem_we),                   64'(e.m.we));
                chk("mem_w_addr",     64'(mem_w_addr),               64'(e.m.w_addr));
                chk("mem_w_data",     64'(mem_w_data),               64'(e.m.w_data));
                chk("mem_hi",         64'(mem_hi),                   64'(e.m.hi));
                chk("mem_lo",         64'(mem_lo),                   64'(e.m.lo));
                chk("mem_hilo",       64'(mem_hilo),                 64'(e.m.hilo));
                chk("mem_aluop",      64'(mem_aluop),                64'(e.m.aluop));
                chk("mem_mem_addr",   64'(mem_mem_addr),             64'(e.m.mem_addr));
                chk("mem_reg2",       64'(mem_reg2),                 64'(e.m.reg2));
                chk("mem_cp0_we",     64'(mem_cp0_reg_we),           64'(e.m.cp0_we));
                chk("mem_cp0_addr",   64'(mem_cp0_reg_write_addr),   64'(e.m.cp0_addr));
                chk("mem_cp0_data",   64'(mem_cp0_reg_data),         64'(e.m.cp0_data));
                chk("mem_excepttype", 64'(mem_excepttype),           64'(e.m.exc));
                chk("mem_delayslot",  64'(mem_is_in_delayslot),      64'(e.m.ds));
                chk("mem_pc",         64'(mem_current_inst_address), 64'(e.m.pc));
                chk("hilo_o",         hilo_o,                        e.hilo);
                chk("cnt_o",          64'(cnt_o),                    64'(e.cnt));
            end
        end
    end

    initial begin : driver
        stage_t s;
        logic [5:0] st;
        rst = 1'b1; flush = 1'b0; stall = 6'd0; ex = zero_stage();
        hilo_i = 64'd0; cnt_i = 2'd0;
        model.m = zero_stage(); model.hilo = 64'd0; model.cnt = 2'd0;

        // Reset with every input driven high.
        repeat (2) issue(1'b1, 1'b0, 6'b001111, ones_stage(), {64{1'b1}}, 2'b11);

        // Plain advance of a load.
        s = zero_stage();
        s.we = 1'b1; s.w_addr = 5'd3; s.w_data = 32'h1234_5678;
        s.aluop = EXE_LW_OP; s.mem_addr = 32'h0000_0104;
        issue(1'b0, 1'b0, 6'b000000, s, 64'hAAAA_5555_AAAA_5555, 2'b10);

        // MADD stall: bubble carries the partial product, then advance clears it.
        issue(1'b0, 1'b0, 6'b001111, rnd_stage(), 64'h0000_0001_0000_0002, 2'b01);
        issue(1'b0, 1'b0, 6'b000000, s, 64'h0000_0003_0000_0004, 2'b10);

        // Hold: DEADBEEF stays put; a prior bubble leaves nonzero accumulator state.
        s.w_data = 32'hDEAD_BEEF;
        issue(1'b0, 1'b0, 6'b000000, s, 64'd0, 2'd0);
        issue(1'b0, 1'b0, 6'b011111, rnd_stage(), $urandom, 2'($urandom));
        issue(1'b0, 1'b0, 6'b000000, s, 64'd0, 2'd0);
        repeat (3) issue(1'b0, 1'b0, 6'b011111, rnd_stage(), {$urandom, $urandom}, 2'($urandom));
        issue(1'b0, 1'b0, 6'b001111, rnd_stage(), 64'h1111_2222_3333_4444, 2'b11);
        repeat (2) issue(1'b0, 1'b0, 6'b011111, rnd_stage(), {$urandom, $urandom}, 2'($urandom));

        // Flush wins over hold.
        issue(1'b0, 1'b1, 6'b011111, rnd_stage(), {$urandom, $urandom}, 2'b11);

        // Exception info passes through, then reset clears it.
        s = zero_stage();
        s.exc = 32'h0000_0200; s.ds = 1'b1; s.pc = 32'hBFC0_0010;
        issue(1'b0, 1'b0, 6'b000000, s, 64'd0, 2'd0);
        issue(1'b1, 1'b0, 6'b000000, s, 64'd0, 2'd0);

        // Random traffic; the illegal stall[4]-only combo is never driven.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: st = 6'b000000;
                1: st = 6'b000111;
                2: st = 6'b001111;
                3: st = 6'b011111;
                4: st = 6'b111111;
                default: st = 6'($urandom);
            endcase
            if (st[4]) st[3] = 1'b1;
            issue($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, st,
                  rnd_stage(), {$urandom, $urandom}, 2'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
